// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha256_sched_pkg;

   localparam int ADDR_W    = 16;
   localparam int CYC_W     = 32;
   localparam int JOB_TAG_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      REPORT
   } sched_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]    msg_addr;
      logic [ADDR_W-1:0]    out_addr;
      logic [JOB_TAG_W-1:0] tag;
   } job_t;

endpackage

// File: rtl/sha256_job_fifo.sv
// Synchronous job queue with registered full/empty flags.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sha256_job_fifo
   import sha256_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push_i,
   input  job_t push_data_i,
   input  logic pop_i,
   output job_t pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   job_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; the flags guard every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o     = full_q;
   assign empty_o    = empty_q;

endmodule

// File: rtl/sha256_job_scheduler.sv
// Queues hash jobs and issues them one at a time to a simplified_sha256 core.
// Optional watchdog in WAIT enabled by SHA_JOB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a queued job
// START  | core_start held high for START_CYCLES cycles
// WAIT   | counting until a core_done rising edge (or watchdog)
// REPORT | completion record held until cmp_ready
module sha256_job_scheduler
   import sha256_sched_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TAG_W          = JOB_TAG_W,
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_msg_addr,
   input  logic [ADDR_W-1:0] req_out_addr,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              core_start,
   output logic [ADDR_W-1:0] core_message_addr,
   output logic [ADDR_W-1:0] core_output_addr,
   input  logic              core_done,
   output logic              cmp_valid,
   input  logic              cmp_ready,
   output logic [TAG_W-1:0]  cmp_tag,
   output logic [CYC_W-1:0]  cmp_cycles,
   output logic              cmp_timeout,
   output logic              busy
);

   localparam int               SC_W        = $clog2(START_CYCLES) + 1;
   localparam logic [SC_W-1:0]  START_LOAD  = SC_W'(START_CYCLES - 1);
   localparam logic [CYC_W-1:0] TIMEOUT_LIM = CYC_W'(TIMEOUT_CYCLES);

   sched_state_e      state_q, state_d;
   logic [SC_W-1:0]   start_cnt_q, start_cnt_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
   logic              done_q, done_d;
   logic              start_q, start_d;
   logic [ADDR_W-1:0] msg_q, msg_d, out_q, out_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              cmp_valid_q, cmp_valid_d;
   logic [CYC_W-1:0]  cmp_cycles_q, cmp_cycles_d;
   logic              cmp_timeout_q, cmp_timeout_d;
   logic              done_edge, timeout_hit;
   logic              fifo_pop, fifo_full, fifo_empty;
   job_t              req_job, head_job;

   assign req_job = {req_msg_addr, req_out_addr, req_tag};

   sha256_job_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (req_valid && !fifo_full),
      .push_data_i (req_job),
      .pop_i       (fifo_pop),
      .pop_data_o  (head_job),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign cyc_inc   = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
   assign done_edge = core_done && !done_q;

`ifdef SHA_JOB_TIMEOUT_EN
   assign timeout_hit = (cyc_inc >= TIMEOUT_LIM);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      start_cnt_d   = start_cnt_q;
      cyc_d         = cyc_q;
      done_d        = core_done;
      start_d       = start_q;
      msg_d         = msg_q;
      out_d         = out_q;
      tag_d         = tag_q;
      cmp_valid_d   = cmp_valid_q;
      cmp_cycles_d  = cmp_cycles_q;
      cmp_timeout_d = cmp_timeout_q;
      fifo_pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               msg_d       = head_job.msg_addr;
               out_d       = head_job.out_addr;
               tag_d       = head_job.tag;
               cyc_d       = '0;
               start_cnt_d = START_LOAD;
               start_d     = 1'b1;
               // A done level held over from the previous job must see a fresh rise.
               done_d      = 1'b0;
               state_d     = START;
            end
         end
         START: begin
            cyc_d = cyc_inc;
            if (start_cnt_q == '0) begin
               start_d = 1'b0;
               state_d = WAIT;
            end else begin
               start_cnt_d = start_cnt_q - 1'b1;
            end
         end
         WAIT: begin
            cyc_d = cyc_inc;
            if (done_edge) begin
               cmp_valid_d   = 1'b1;
               cmp_cycles_d  = cyc_inc;
               cmp_timeout_d = 1'b0;
               state_d       = REPORT;
            end else if (timeout_hit) begin
               cmp_valid_d   = 1'b1;
               cmp_cycles_d  = TIMEOUT_LIM;
               cmp_timeout_d = 1'b1;
               state_d       = REPORT;
            end
         end
         REPORT: begin
            if (cmp_ready) begin
               cmp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         start_cnt_q   <= '0;
         cyc_q         <= '0;
         done_q        <= 1'b0;
         start_q       <= 1'b0;
         msg_q         <= '0;
         out_q         <= '0;
         tag_q         <= '0;
         cmp_valid_q   <= 1'b0;
         cmp_cycles_q  <= '0;
         cmp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         cyc_q         <= cyc_d;
         done_q        <= done_d;
         start_q       <= start_d;
         msg_q         <= msg_d;
         out_q         <= out_d;
         tag_q         <= tag_d;
         cmp_valid_q   <= cmp_valid_d;
         cmp_cycles_q  <= cmp_cycles_d;
         cmp_timeout_q <= cmp_timeout_d;
      end
   end

   assign req_ready         = !fifo_full;
   assign core_start        = start_q;
   assign core_message_addr = msg_q;
   assign core_output_addr  = out_q;
   assign cmp_valid         = cmp_valid_q;
   assign cmp_tag           = tag_q;
   assign cmp_cycles        = cmp_cycles_q;
   assign cmp_timeout       = cmp_timeout_q;
   assign busy              = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Scoreboard bench for sha256_job_scheduler with a behavioural core model.
// Builds with SHA_JOB_TIMEOUT_EN add a watchdog scenario with TIMEOUT_CYCLES=64.
module tb_sha256_job_scheduler;

   localparam int START_CYCLES = 2;
`ifdef SHA_JOB_TIMEOUT_EN
   localparam int TO_CYC = 64;
`else
   localparam int TO_CYC = 100000;
`endif

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_msg_addr;
   logic [15:0] req_out_addr;
   logic [3:0]  req_tag;
   logic        core_start;
   logic [15:0] core_message_addr;
   logic [15:0] core_output_addr;
   logic        core_done;
   logic        cmp_valid;
   logic        cmp_ready;
   logic [3:0]  cmp_tag;
   logic [31:0] cmp_cycles;
   logic        cmp_timeout;
   logic        busy;

   sha256_job_scheduler #(
      .FIFO_DEPTH     (4),
      .TAG_W          (4),
      .START_CYCLES   (START_CYCLES),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_msg_addr      (req_msg_addr),
      .req_out_addr      (req_out_addr),
      .req_tag           (req_tag),
      .core_start        (core_start),
      .core_message_addr (core_message_addr),
      .core_output_addr  (core_output_addr),
      .core_done         (core_done),
      .cmp_valid         (cmp_valid),
      .cmp_ready         (cmp_ready),
      .cmp_tag           (cmp_tag),
      .cmp_cycles        (cmp_cycles),
      .cmp_timeout       (cmp_timeout),
      .busy              (busy)
   );

   typedef struct {
      logic [15:0] msg;
      logic [15:0] out;
      int          delay;
      bit          hold;
   } issue_t;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] cycles;
      logic        to;
   } cmp_t;

   issue_t issue_q[$];
   cmp_t   cmp_q[$];
   issue_t ie;
   cmp_t   ce;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic start_prev = 1'b0;
   int   start_len = 0;
   bit   core_active = 1'b0;
   bit   core_hold = 1'b0;
   int   core_cnt = 0;
   int   hs_cyc = 0;
   bit   gap_armed = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Core model and completion scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (core_start && !start_prev) begin
            start_len = 1;
            checks++;
            if (issue_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_start at cycle %0d: core_start=1 required 0", cyc);
               core_active = 1'b0;
            end else begin
               ie = issue_q.pop_front();
               if (core_message_addr !== ie.msg || core_output_addr !== ie.out) begin
                  errors++;
                  $display("FAIL start_addr got msg %h out %h required msg %h out %h",
                           core_message_addr, core_output_addr, ie.msg, ie.out);
               end
               core_cnt    = ie.delay;
               core_active = (ie.delay != 0);
               core_hold   = ie.hold;
               if (!ie.hold) core_done = 1'b0;
            end
            if (gap_armed) begin
               checks++;
               if (cyc - hs_cyc != 2) begin
                  errors++;
                  $display("FAIL start_gap got %0d cycles required 2", cyc - hs_cyc);
               end
               gap_armed = 1'b0;
            end
         end else begin
            if (core_start) start_len++;
            if (!core_start && start_prev) begin
               checks++;
               if (start_len != START_CYCLES) begin
                  errors++;
                  $display("FAIL start_len got %0d required %0d", start_len, START_CYCLES);
               end
            end
            if (core_active) begin
               core_cnt--;
               if (core_hold && core_cnt == 10) core_done = 1'b0;
               if (core_cnt == 0) begin
                  core_done   = 1'b1;
                  core_active = 1'b0;
               end
            end
         end
         if (cmp_valid && cmp_ready) begin
            checks++;
            if (cmp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cmp tag %0d cycles %0d", cmp_tag, cmp_cycles);
            end else begin
               ce = cmp_q.pop_front();
               if (cmp_tag !== ce.tag || cmp_cycles !== ce.cycles || cmp_timeout !== ce.to) begin
                  errors++;
                  $display("FAIL cmp_record got tag %0d cycles %0d to %b required tag %0d cycles %0d to %b",
                           cmp_tag, cmp_cycles, cmp_timeout, ce.tag, ce.cycles, ce.to);
               end
            end
            hs_cyc    = cyc;
            gap_armed = (issue_q.size() != 0);
         end
         start_prev = core_start;
      end
   end

   task automatic send_job(input logic [15:0] msg, input logic [15:0] out,
                           input logic [3:0] tag, input int delay, input bit hold);
      int     waited;
      issue_t ni;
      cmp_t   nc;
      waited = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_ready_timeout tag %0d req_ready=%b required 1", tag, req_ready);
         return;
      end
      req_valid    = 1'b1;
      req_msg_addr = msg;
      req_out_addr = out;
      req_tag      = tag;
      @(posedge clk);
      ni.msg   = msg;
      ni.out   = out;
      ni.delay = delay;
      ni.hold  = hold;
      issue_q.push_back(ni);
      nc.tag    = tag;
      nc.cycles = 32'(delay + 1);
      nc.to     = 1'b0;
`ifdef SHA_JOB_TIMEOUT_EN
      if (delay == 0 || delay + 1 > TO_CYC) begin
         nc.cycles = 32'(TO_CYC);
         nc.to     = 1'b1;
      end
`endif
      cmp_q.push_back(nc);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((issue_q.size() != 0 || cmp_q.size() != 0 || cmp_valid !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout pending issue %0d cmp %0d required 0 0",
                  issue_q.size(), cmp_q.size());
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy got %b required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_msg_addr = '0;
      req_out_addr = '0;
      req_tag      = '0;
      core_done    = 1'b0;
      cmp_ready    = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (core_start !== 1'b0 || cmp_valid !== 1'b0 || cmp_timeout !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || core_message_addr !== 16'h0 || core_output_addr !== 16'h0 ||
          cmp_tag !== 4'h0 || cmp_cycles !== 32'h0) begin
         errors++;
         $display("FAIL reset_values got start %b valid %b to %b busy %b ready %b msg %h out %h tag %h cyc %h required all 0 with ready 1",
                  core_start, cmp_valid, cmp_timeout, busy, req_ready,
                  core_message_addr, core_output_addr, cmp_tag, cmp_cycles);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || cmp_valid !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got ready %b busy %b valid %b start %b required 1 0 0 0",
                  req_ready, busy, cmp_valid, core_start);
      end
   endtask

   task automatic test_single_job();
      send_job(16'd0, 16'd1000, 4'd3, 500, 1'b0);
      wait_drain(2000);
   endtask

   task automatic test_back_to_back();
      int n;
      send_job(16'h1111, 16'h2222, 4'd9, 200, 1'b0);
      n = 0;
      while (issue_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         send_job(16'(16'h0010 * i), 16'(16'h2000 + i), 4'(i), 20 + 7 * i, 1'b0);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready got %b required 0", req_ready);
      end
      wait_drain(3000);
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      cmp_ready = 1'b0;
      send_job(16'h0100, 16'h0200, 4'd1, 30, 1'b0);
      send_job(16'h0300, 16'h0400, 4'd2, 40, 1'b0);
      n = 0;
      while (cmp_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmp_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_cmp_timeout cmp_valid=%b required 1", cmp_valid);
      end
      for (int i = 0; i < 3; i++) begin
         send_job(16'(16'h0500 + i), 16'(16'h0600 + i), 4'(i + 3), 15, 1'b0);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_ready got %b required 0", req_ready);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (cmp_valid !== 1'b1 || cmp_tag !== 4'd1 || cmp_cycles !== 32'd31 ||
             cmp_timeout !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall cycle %0d got valid %b tag %0d cycles %0d to %b start %b required 1 1 31 0 0",
                     i, cmp_valid, cmp_tag, cmp_cycles, cmp_timeout, core_start);
         end
      end
      cmp_ready = 1'b1;
      wait_drain(2000);
   endtask

   task automatic test_done_hold();
      send_job(16'h0a00, 16'h0b00, 4'd4, 100, 1'b0);
      send_job(16'h0c00, 16'h0d00, 4'd5, 300, 1'b1);
      wait_drain(2000);
   endtask

   task automatic test_reset_mid_job();
      int n;
      send_job(16'h5555, 16'h6666, 4'd7, 0, 1'b0);
      send_job(16'h5556, 16'h6667, 4'd8, 50, 1'b0);
      send_job(16'h5557, 16'h6668, 4'd9, 50, 1'b0);
      n = 0;
      while (issue_q.size() != 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (core_start !== 1'b0 || cmp_valid !== 1'b0 || cmp_timeout !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || core_message_addr !== 16'h0 || core_output_addr !== 16'h0 ||
          cmp_tag !== 4'h0 || cmp_cycles !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_values got start %b valid %b to %b busy %b ready %b msg %h out %h tag %h cyc %h required all 0 with ready 1",
                  core_start, cmp_valid, cmp_timeout, busy, req_ready,
                  core_message_addr, core_output_addr, cmp_tag, cmp_cycles);
      end
      issue_q.delete();
      cmp_q.delete();
      core_active = 1'b0;
      core_done   = 1'b0;
      start_prev  = 1'b0;
      gap_armed   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (cmp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL after_reset cycle %0d got valid %b busy %b ready %b start %b required 0 0 1 0",
                     i, cmp_valid, busy, req_ready, core_start);
         end
      end
   endtask

`ifdef SHA_JOB_TIMEOUT_EN
   task automatic test_timeout();
      send_job(16'h7000, 16'h7100, 4'd10, 0, 1'b0);
      send_job(16'h7200, 16'h7300, 4'd11, 20, 1'b0);
      wait_drain(1000);
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL global_timeout simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

   initial begin
      test_reset();
      test_single_job();
      test_back_to_back();
      test_backpressure();
      test_done_hold();
      test_reset_mid_job();
`ifdef SHA_JOB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
